// File: rtl/sample_frame_dispatcher_pkg.sv
// Shared defaults and helpers for the sample frame dispatcher.
package sample_frame_dispatcher_pkg;

  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_CNT_WIDTH    = 16;

  // Output stage occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Width of a channel index; never narrower than one bit so a
  // single-channel build still has a legal index port.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sample_frame_dispatcher_out.sv
// Output frame register with EMPTY/FULL handshake and delivery/drop counters.
module frame_out_stage
  import sample_frame_dispatcher_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               complete_i,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] frame_i,
  input  logic                               ready_i,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] frame_o,
  output logic                               valid_o,
  output logic [CNT_WIDTH-1:0]               frame_count_o,
  output logic [CNT_WIDTH-1:0]               drop_count_o,
  output logic                               overflow_o
);

  out_state_e                         state_q;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] frame_q;
  logic [CNT_WIDTH-1:0]               frame_cnt_q;
  logic [CNT_WIDTH-1:0]               drop_cnt_q;
  logic                               ovf_q;

  // Load / consume / drop decisions; a held frame is never overwritten
  // unless it is consumed in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      frame_q     <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (complete_i) begin
            frame_q <= frame_i;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (ready_i) begin
            frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
            if (complete_i) frame_q <= frame_i;
            else            state_q <= ST_EMPTY;
          end else if (complete_i) begin
            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
            ovf_q <= 1'b1;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign frame_o       = frame_q;
  assign valid_o       = (state_q == ST_FULL);
  assign frame_count_o = frame_cnt_q;
  assign drop_count_o  = drop_cnt_q;
  assign overflow_o    = ovf_q;

endmodule

// File: rtl/sample_frame_dispatcher.sv
// Gathers a serial sample stream into NUM_CHANNELS-wide frames and hands
// each completed frame to a single-entry output stage.
module sample_frame_dispatcher
  import sample_frame_dispatcher_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int IDX_W        = idx_width(NUM_CHANNELS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_WIDTH-1:0]              sample_in,
  input  logic                               sample_valid_in,
  input  logic                               frame_sync_in,
  input  logic                               frame_ready_in,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] frame_data_out,
  output logic                               frame_valid_out,
  output logic [IDX_W-1:0]                   wr_index_out,
  output logic [CNT_WIDTH-1:0]               frame_count_out,
  output logic [CNT_WIDTH-1:0]               drop_count_out,
  output logic                               overflow_out,
  output logic                               short_frame_out
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]                        wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]                        slot;
  logic                                    short_q, short_d;
  logic                                    complete;

  // Slot selection and accumulator update; a sync sample restarts at slot 0,
  // and the final sample is merged into acc_d so the output stage can load
  // the whole frame on the completing cycle.
  always_comb begin
    slot     = frame_sync_in ? '0 : wr_idx_q;
    acc_d    = acc_q;
    wr_idx_d = wr_idx_q;
    short_d  = 1'b0;
    complete = 1'b0;
    if (sample_valid_in) begin
      acc_d[slot] = sample_in;
      short_d     = frame_sync_in && (wr_idx_q != '0);
      if (slot == LAST_IDX) begin
        complete = 1'b1;
        wr_idx_d = '0;
      end else begin
        wr_idx_d = slot + IDX_W'(1);
      end
    end
  end

  // Accumulator, write index and truncation pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      wr_idx_q <= '0;
      short_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      wr_idx_q <= wr_idx_d;
      short_q  <= short_d;
    end
  end

  frame_out_stage #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .DATA_WIDTH   (DATA_WIDTH),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_out (
    .clk           (clk),
    .rst_n         (rst_n),
    .complete_i    (complete),
    .frame_i       (acc_d),
    .ready_i       (frame_ready_in),
    .frame_o       (frame_data_out),
    .valid_o       (frame_valid_out),
    .frame_count_o (frame_count_out),
    .drop_count_o  (drop_count_out),
    .overflow_o    (overflow_out)
  );

  assign wr_index_out    = wr_idx_q;
  assign short_frame_out = short_q;

endmodule

// File: tb/tb_sample_frame_dispatcher.sv
// Directed bench: spec-level frame model checked every cycle, plus literal
// expectations for the worked examples, and a single-channel instance.
module tb_sample_frame_dispatcher;

  localparam int N = 4;
  localparam int D = 16;
  localparam int C = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [D-1:0]  s_in;
  logic          s_vld, s_sync, rdy;
  logic [N*D-1:0] f_data;
  logic          f_valid;
  logic [1:0]    widx;
  logic [C-1:0]  fc, dc;
  logic          ovf, shrt;

  logic [D-1:0]  bs_in;
  logic          bs_vld, bs_sync, brdy;
  logic [D-1:0]  b_data;
  logic          b_valid;
  logic [0:0]    b_widx;
  logic [3:0]    b_fc, b_dc;
  logic          b_ovf, b_short;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  sample_frame_dispatcher #(.NUM_CHANNELS(N), .DATA_WIDTH(D), .CNT_WIDTH(C)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(s_in), .sample_valid_in(s_vld),
    .frame_sync_in(s_sync), .frame_ready_in(rdy), .frame_data_out(f_data),
    .frame_valid_out(f_valid), .wr_index_out(widx), .frame_count_out(fc),
    .drop_count_out(dc), .overflow_out(ovf), .short_frame_out(shrt));

  sample_frame_dispatcher #(.NUM_CHANNELS(1), .DATA_WIDTH(D), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .sample_in(bs_in), .sample_valid_in(bs_vld),
    .frame_sync_in(bs_sync), .frame_ready_in(brdy), .frame_data_out(b_data),
    .frame_valid_out(b_valid), .wr_index_out(b_widx), .frame_count_out(b_fc),
    .drop_count_out(b_dc), .overflow_out(b_ovf), .short_frame_out(b_short));

  // Model: pending samples of the partial frame, plus the output frame.
  logic [D-1:0]   part[$];
  logic           m_valid, m_ovf, m_short;
  logic [N*D-1:0] m_data;
  logic [C-1:0]   m_fc, m_dc;
  int             m_widx;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic cmp;
    logic [N*D-1:0] nf;
    cmp = 1'b0;
    nf  = '0;
    if (!rst_n) begin
      part.delete();
      m_valid = 0; m_ovf = 0; m_short = 0; m_data = '0;
      m_fc = '0; m_dc = '0; m_widx = 0;
    end else begin
      m_short = 1'b0;
      if (s_vld) begin
        if (s_sync) begin
          if (part.size() != 0) m_short = 1'b1;
          part.delete();
        end
        part.push_back(s_in);
        if (part.size() == N) begin
          cmp = 1'b1;
          for (int i = 0; i < N; i++) nf[i*D +: D] = part[i];
          part.delete();
        end
      end
      if (m_valid) begin
        if (rdy) begin
          m_fc = m_fc + 1'b1;
          if (cmp) m_data = nf;
          else     m_valid = 1'b0;
        end else if (cmp) begin
          if (m_dc != '1) m_dc = m_dc + 1'b1;
          m_ovf = 1'b1;
        end
      end else if (cmp) begin
        m_data  = nf;
        m_valid = 1'b1;
      end
      m_widx = part.size();
    end
  endtask

  // Every-cycle comparison of the 4-channel DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 64'(f_valid), 64'(m_valid));
      chk("data", 64'(f_data), 64'(m_data));
      chk("wr_index", 64'(widx), 64'(m_widx));
      chk("frame_count", 64'(fc), 64'(m_fc));
      chk("drop_count", 64'(dc), 64'(m_dc));
      chk("overflow", 64'(ovf), 64'(m_ovf));
      chk("short", 64'(shrt), 64'(m_short));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic send(input logic [D-1:0] d, input logic sy);
    s_vld = 1'b1; s_in = d; s_sync = sy;
    cyc();
    s_vld = 1'b0; s_sync = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; s_in = '0; s_vld = 0; s_sync = 0; rdy = 0;
    bs_in = '0; bs_vld = 0; bs_sync = 0; brdy = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst_n = 1'b1;
    chk("rst_valid", 64'(f_valid), 64'd0);
    chk("rst_fc", 64'(fc), 64'd0);
    chk("rst_data", 64'(f_data), 64'd0);

    // Basic frame with ready held high.
    rdy = 1'b1;
    send(16'd1, 1'b1); send(16'd2, 1'b0); send(16'd3, 1'b0); send(16'd4, 1'b0);
    chk("t1_valid", 64'(f_valid), 64'd1);
    chk("t1_data", 64'(f_data), 64'h0004_0003_0002_0001);
    cyc();
    chk("t1_fc", 64'(fc), 64'd1);
    chk("t1_consumed", 64'(f_valid), 64'd0);

    // Sync without valid is ignored; ready in EMPTY does nothing.
    s_sync = 1'b1; cyc(); s_sync = 1'b0;
    chk("sync_noval_widx", 64'(widx), 64'd0);
    chk("ready_empty_fc", 64'(fc), 64'd1);

    // Two frames while stalled: second is dropped.
    do_reset();
    rdy = 1'b0;
    send(16'h11, 1'b1); send(16'h12, 1'b0); send(16'h13, 1'b0); send(16'h14, 1'b0);
    send(16'h21, 1'b1); send(16'h22, 1'b0); send(16'h23, 1'b0); send(16'h24, 1'b0);
    chk("t2_data", 64'(f_data), 64'h0014_0013_0012_0011);
    chk("t2_dc", 64'(dc), 64'd1);
    chk("t2_ovf", 64'(ovf), 64'd1);
    chk("t2_fc", 64'(fc), 64'd0);
    rdy = 1'b1; cyc();
    chk("t2_fc_after", 64'(fc), 64'd1);
    chk("t2_ovf_sticky", 64'(ovf), 64'd1);

    // Truncated frame then resync.
    rdy = 1'b0;
    send(16'd1, 1'b1); send(16'd2, 1'b0); send(16'd9, 1'b1);
    chk("t3_short", 64'(shrt), 64'd1);
    send(16'd8, 1'b0);
    chk("t3_short_once", 64'(shrt), 64'd0);
    send(16'd7, 1'b0); send(16'd6, 1'b0);
    chk("t3_data", 64'(f_data), 64'h0006_0007_0008_0009);
    chk("t3_fc", 64'(fc), 64'd1);
    rdy = 1'b1; cyc();
    chk("t3_fc_after", 64'(fc), 64'd2);

    // Completion while FULL with ready in the same cycle.
    rdy = 1'b0;
    send(16'hA1, 1'b1); send(16'hA2, 1'b0); send(16'hA3, 1'b0); send(16'hA4, 1'b0);
    send(16'hB1, 1'b1); send(16'hB2, 1'b0); send(16'hB3, 1'b0);
    rdy = 1'b1;
    send(16'hB4, 1'b0);
    chk("t4_valid", 64'(f_valid), 64'd1);
    chk("t4_data", 64'(f_data), 64'h00B4_00B3_00B2_00B1);
    chk("t4_fc", 64'(fc), 64'd3);
    chk("t4_dc", 64'(dc), 64'd1);
    cyc();
    chk("t4_fc_after", 64'(fc), 64'd4);

    // Reset mid-frame discards the partial samples.
    send(16'h51, 1'b1); send(16'h52, 1'b0);
    do_reset();
    chk("t5_fc", 64'(fc), 64'd0);
    chk("t5_widx", 64'(widx), 64'd0);
    chk("t5_ovf", 64'(ovf), 64'd0);
    chk("t5_data", 64'(f_data), 64'd0);
    send(16'h61, 1'b0); send(16'h62, 1'b0); send(16'h63, 1'b0); send(16'h64, 1'b0);
    chk("t5_frame", 64'(f_data), 64'h0064_0063_0062_0061);
    cyc();
    chk("t5_fc_after", 64'(fc), 64'd1);
    chk("t5_dc", 64'(dc), 64'd0);

    // Single-channel instance: every sample is a frame, counter wraps.
    for (int k = 1; k <= 20; k++) begin
      bs_in = 16'(k); bs_vld = 1'b1; bs_sync = (k % 3 == 0);
      cyc();
      chk("n1_valid", 64'(b_valid), 64'd1);
      chk("n1_data", 64'(b_data), 64'(k));
      chk("n1_short", 64'(b_short), 64'd0);
      chk("n1_fc", 64'(b_fc), 64'((k - 1) % 16));
    end
    bs_vld = 1'b0; bs_sync = 1'b0;
    cyc();
    chk("n1_fc_wrap", 64'(b_fc), 64'd4);
    chk("n1_dc", 64'(b_dc), 64'd0);
    chk("n1_empty", 64'(b_valid), 64'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
